// File: rtl/rst_seq.sv
// Reset sequencer for the AES core domain: qualifies MMCM lock, holds core
// reset for a fixed time, re-asserts on lock loss or soft reset, counts lock losses.
module rst_seq #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 16,
    parameter int RST_HOLD_CYCLES    = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_locked,
    input  logic       i_soft_rst,
    output logic       o_core_rst_n,
    output logic       o_ready,
    output logic [7:0] o_lock_loss_cnt
);

    localparam int MAX_CYCLES = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ?
                                LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES) + 1;
    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(RST_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_STABLE    = 2'd1,
        S_HOLD      = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    // Debug counter sticks at full scale rather than wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            sat_inc8 = 8'hFF;
        end else begin
            sat_inc8 = v + 8'd1;
        end
    endfunction

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   locked_s;
    state_t                 state_r;
    state_t                 state_next_s;
    logic [CW-1:0]          cnt_r;
    logic [CW-1:0]          cnt_next_s;
    logic                   lock_lost_s;
    logic                   core_rst_n_r;
    logic                   ready_r;
    logic [7:0]             loss_cnt_r;

    // Synchronizer chain: the only place i_locked is sampled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], i_locked};
        end
    end

    assign locked_s = sync_r[SYNC_STAGES-1];

    // Next-state and counter logic; lock loss outranks soft reset outranks counting.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    state_next_s = S_STABLE;
                end else begin
                    state_next_s = S_WAIT_LOCK;
                end
            end
            S_STABLE: begin
                if (!locked_s) begin
                    state_next_s = S_WAIT_LOCK;
                end else if (cnt_r == STABLE_LAST) begin
                    state_next_s = S_HOLD;
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end
            S_HOLD: begin
                if (!locked_s) begin
                    state_next_s = S_WAIT_LOCK;
                end else if (i_soft_rst) begin
                    cnt_next_s = CNT_ZERO;
                end else if (cnt_r == HOLD_LAST) begin
                    state_next_s = S_RUN;
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_next_s = S_WAIT_LOCK;
                end else if (i_soft_rst) begin
                    state_next_s = S_HOLD;
                end else begin
                    state_next_s = S_RUN;
                end
            end
            default: begin
                state_next_s = S_WAIT_LOCK;
            end
        endcase
        // Any state change starts the new phase from a zero count.
        if (state_next_s != state_r) begin
            cnt_next_s = CNT_ZERO;
        end else begin
            cnt_next_s = cnt_next_s;
        end
        lock_lost_s = (state_r != S_WAIT_LOCK) && (state_next_s == S_WAIT_LOCK);
    end

    // State, counter and registered outputs; ready lags core reset release by one edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r      <= S_WAIT_LOCK;
            cnt_r        <= CNT_ZERO;
            core_rst_n_r <= 1'b0;
            ready_r      <= 1'b0;
            loss_cnt_r   <= 8'd0;
        end else begin
            state_r      <= state_next_s;
            cnt_r        <= cnt_next_s;
            core_rst_n_r <= (state_next_s == S_RUN);
            ready_r      <= core_rst_n_r && (state_next_s == S_RUN);
            if (lock_lost_s) begin
                loss_cnt_r <= sat_inc8(loss_cnt_r);
            end else begin
                loss_cnt_r <= loss_cnt_r;
            end
        end
    end

    assign o_core_rst_n    = core_rst_n_r;
    assign o_ready         = ready_r;
    assign o_lock_loss_cnt = loss_cnt_r;

endmodule
